// File: rtl/data_packer_mp.sv
// data_packer_mp: packs N/M/1-element full/half precision vectors into dense N-lane words
module data_packer_mp #(
  parameter int N = 8,
  parameter int M = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE = '0,
  parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_COND = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tracing,
  input  logic valid_in,
  input  logic [1:0] eof_in,
  input  logic [1:0] bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic [7:0] configId,
  input  logic [7:0] configData,
  input  logic [N*DATA_WIDTH-1:0] vector_in,
  output logic [N*DATA_WIDTH-1:0] vector_out,
  output logic [N-1:0] lane_half_out,
  output logic valid_out
);
  localparam int HW = DATA_WIDTH / 2;
  localparam int W = N * DATA_WIDTH;
  localparam int CW = $clog2(2 * N + 1);
  localparam int BW = $clog2(2 * MAX_CHAINS + 1);
  logic [W-1:0] pack_q, pack_d, pend_q, img_h, img_f, img, comb_d, norm_word;
  logic [N-1:0] mask_q, mask_d, pend_mask_q, img_m, comb_m, norm_mask;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bc_q;
  logic [7:0] fw_q [MAX_CHAINS];
  logic [7:0] fc_q [MAX_CHAINS];
  logic [7:0] cond;
  logic [2:0] mode;
  logic [31:0] len, s_in, cnt32, cp, total, bc32;
  logic pend_v, trc_q, half, cond_ok, take, flush, norm_emit, ld_pend;
  assign cnt32 = 32'(cnt_q);
  assign bc32 = 32'(bc_q);
  // Decode the selected chain, build the incoming slot image and the next packing state
  always_comb begin
    mode = fw_q[chainId_in][2:0];
    cond = fc_q[chainId_in];
    half = mode[2];
    len = mode[1:0] == 2'd0 ? N : mode[1:0] == 2'd1 ? M : 1;
    s_in = half ? len : 2 * len;
    cp = cnt32 + {31'b0, ~half & cnt_q[0]};
    total = cp + s_in;
    cond_ok = cond == '0 || |(cond & {~bof_in[1], bof_in[1], ~eof_in[1], eof_in[1],
                                      ~bof_in[0], bof_in[0], ~eof_in[0], eof_in[0]});
    take = valid_in & tracing & (mode[1:0] != 2'd3) & cond_ok;
    flush = trc_q & ~tracing;
    img_h = '0;
    img_f = '0;
    img_m = '0;
    comb_m = mask_q;
    for (int k = 0; k < N; k++) begin
      img_h[k*HW +: HW] = k < len ? vector_in[k*DATA_WIDTH +: HW] : '0;
      img_f[k*DATA_WIDTH +: DATA_WIDTH] = k < len ? vector_in[k*DATA_WIDTH +: DATA_WIDTH] : '0;
      img_m[k] = half && 2 * k < s_in;
      comb_m[k] = mask_q[k] | (half && 2 * k + 1 >= cp && 2 * k < total);
    end
    img = half ? img_h : img_f;
    comb_d = pack_q | (img << (cp * HW));
    norm_emit = 1'b0;
    norm_word = pack_q;
    norm_mask = mask_q;
    pack_d = pack_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    ld_pend = 1'b0;
    if (take) begin
      if (total < 2 * N) begin
        pack_d = comb_d;
        mask_d = comb_m;
        cnt_d = total[CW-1:0];
      end else if (total == 2 * N) begin
        norm_emit = 1'b1;
        norm_word = comb_d;
        norm_mask = comb_m;
        pack_d = '0;
        mask_d = '0;
        cnt_d = '0;
      end else begin
        norm_emit = 1'b1;
        ld_pend = s_in == 2 * N;
        pack_d = ld_pend ? '0 : img;
        mask_d = ld_pend ? '0 : img_m;
        cnt_d = ld_pend ? '0 : s_in[CW-1:0];
      end
    end else if (flush && cnt_q != '0 && !pend_v) begin
      norm_emit = 1'b1;
      pack_d = '0;
      mask_d = '0;
      cnt_d = '0;
    end
  end
  // Packing buffer, pending word and output register; a pending word always wins the output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      pend_v <= 1'b0;
      pend_q <= '0;
      pend_mask_q <= '0;
      trc_q <= 1'b0;
      valid_out <= 1'b0;
      vector_out <= '0;
      lane_half_out <= '0;
    end else begin
      pack_q <= pack_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      trc_q <= tracing;
      valid_out <= pend_v | norm_emit;
      if (pend_v) begin
        vector_out <= pend_q;
        lane_half_out <= pend_mask_q;
      end else if (norm_emit) begin
        vector_out <= norm_word;
        lane_half_out <= norm_mask;
      end
      pend_v <= pend_v ? norm_emit : ld_pend;
      pend_q <= pend_v ? norm_word : img;
      pend_mask_q <= pend_v ? norm_mask : img_m;
    end
  end
  // Configuration byte stream: condition bytes first, then mode bytes, counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q <= '0;
      for (int i = 0; i < MAX_CHAINS; i++) begin
        fw_q[i] <= INITIAL_FIRMWARE[i*8 +: 8];
        fc_q[i] <= INITIAL_FIRMWARE_COND[i*8 +: 8];
      end
    end else if (!tracing) begin
      if (configId == PERSONAL_CONFIG_ID) begin
        for (int i = 0; i < MAX_CHAINS; i++) begin
          if (bc32 == i) fc_q[i] <= configData;
          if (bc32 == i + MAX_CHAINS) fw_q[i] <= configData;
        end
        if (bc32 < 2 * MAX_CHAINS) bc_q <= bc_q + 1'b1;
      end else begin
        bc_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_data_packer_mp.sv
// tb_data_packer_mp: table-driven directed check of the mixed-precision packer
module tb_data_packer_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tracing = 1'b0;
  logic valid_in = 1'b0;
  logic [1:0] eof_in = '0;
  logic [1:0] bof_in = '0;
  logic [1:0] chainId_in = '0;
  logic [7:0] configId = 8'd1;
  logic [7:0] configData = '0;
  logic [255:0] vector_in = '0;
  logic [255:0] vector_out;
  logic [7:0] lane_half_out;
  logic valid_out;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic trc;
    logic vld;
    logic [1:0] eof;
    logic [1:0] ch;
    logic [7:0] cid;
    logic [7:0] cdat;
    logic [255:0] vin;
    logic ev;
    logic [255:0] evec;
    logic [7:0] em;
    string name;
  } row_t;
  row_t rows[$];
  always #5 clk = ~clk;
  data_packer_mp dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in),
    .configId(configId), .configData(configData), .vector_in(vector_in),
    .vector_out(vector_out), .lane_half_out(lane_half_out), .valid_out(valid_out)
  );
  function automatic logic [255:0] ln(input logic [31:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic add(input logic trc, vld, input logic [1:0] eof, ch, input logic [7:0] cid, cdat,
                     input logic [255:0] vin, input logic ev, input logic [255:0] evec,
                     input logic [7:0] em, input string name);
    row_t r;
    r.trc = trc; r.vld = vld; r.eof = eof; r.ch = ch; r.cid = cid; r.cdat = cdat;
    r.vin = vin; r.ev = ev; r.evec = evec; r.em = em; r.name = name;
    rows.push_back(r);
  endtask
  task automatic cfg(input logic [7:0] f0, f1, c0);
    logic [7:0] b [8];
    b = '{c0, 8'h0, 8'h0, 8'h0, f0, f1, 8'h0, 8'h0};
    add(0, 0, 0, 0, 8'd1, 0, 0, 0, 0, 0, "cfg_rst");
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 8'd0, b[i], 0, 0, 0, 0, "cfg");
  endtask
  task automatic inp(input logic [1:0] ch, input logic [255:0] vin, input logic ev,
                     input logic [255:0] evec, input logic [7:0] em, input string name);
    add(1, 1, 0, ch, 8'd1, 0, vin, ev, evec, em, name);
  endtask
  task automatic idle(input logic trc, input logic ev, input logic [255:0] evec,
                      input logic [7:0] em, input string name);
    add(trc, 0, 0, 0, 8'd1, 0, 0, ev, evec, em, name);
  endtask
  initial begin
    cfg(8'h00, 8'h00, 8'h00);
    inp(0, ln(1, 2, 3, 4, 5, 6, 7, 8), 1, ln(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, "t1_full_n");
    idle(1, 0, 0, 0, "t1_idle");
    cfg(8'h01, 8'h00, 8'h00);
    inp(0, ln('h11, 'h12, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD), 0, 0, 0, "t2_a");
    inp(0, ln('h21, 'h22, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD), 0, 0, 0, "t2_b");
    inp(0, ln('h31, 'h32, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD), 0, 0, 0, "t2_c");
    inp(0, ln('h41, 'h42, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD, 'hDEAD), 1,
        ln('h11, 'h12, 'h21, 'h22, 'h31, 'h32, 'h41, 'h42), 8'h00, "t2_m_full");
    cfg(8'h06, 8'h00, 8'h00);
    for (int i = 1; i <= 16; i++)
      inp(0, ln(32'hBEEF0000 | 32'(i), 'hCAFE, 0, 0, 0, 0, 0, 0), i == 16,
          ln('h00020001, 'h00040003, 'h00060005, 'h00080007, 'h000A0009, 'h000C000B,
             'h000E000D, 'h0010000F), 8'hFF, "t3_half1");
    inp(0, ln('h1234AAAA, 'h99, 0, 0, 0, 0, 0, 0), 0, 0, 0, "t4_half");
    inp(1, ln(1, 2, 3, 4, 5, 6, 7, 8), 1, ln('hAAAA, 0, 0, 0, 0, 0, 0, 0), 8'h01, "t4_overflow");
    inp(1, ln(9, 10, 11, 12, 13, 14, 15, 16), 1, ln(1, 2, 3, 4, 5, 6, 7, 8), 8'h00, "t4_pending");
    idle(1, 1, ln(9, 10, 11, 12, 13, 14, 15, 16), 8'h00, "t4_deferred");
    idle(1, 0, 0, 0, "t4_idle");
    cfg(8'h06, 8'h01, 8'h00);
    inp(0, ln('hF00D0A0A, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, "t5_h0");
    inp(0, ln('hF00D0B0B, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, "t5_h1");
    inp(0, ln('hF00D0C0C, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, "t5_h2");
    inp(1, ln('h55550001, 'h66660002, 'hDEAD, 0, 0, 0, 0, 0), 0, 0, 0, "t5_pad_m");
    idle(0, 1, ln('h0B0B0A0A, 'h00000C0C, 'h55550001, 'h66660002, 0, 0, 0, 0), 8'h03, "t5_flush");
    cfg(8'h02, 8'h01, 8'h01);
    add(0, 1, 2'b01, 0, 8'd1, 0, ln('h55, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, "t6_cfg_mode_in");
    add(1, 1, 2'b00, 0, 8'd1, 0, ln('h77, 'hEE, 0, 0, 0, 0, 0, 0), 0, 0, 0, "t6_no_eof");
    add(1, 1, 2'b01, 0, 8'd1, 0, ln('h99, 'hEE, 0, 0, 0, 0, 0, 0), 0, 0, 0, "t6_eof");
    idle(0, 1, ln('h99, 0, 0, 0, 0, 0, 0, 0), 8'h00, "t6_flush");
    #12;
    chk("reset_valid", 256'(valid_out), 256'(0));
    chk("reset_vec", vector_out, '0);
    chk("reset_mask", 256'(lane_half_out), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    foreach (rows[i]) begin
      tracing = rows[i].trc;
      valid_in = rows[i].vld;
      eof_in = rows[i].eof;
      chainId_in = rows[i].ch;
      configId = rows[i].cid;
      configData = rows[i].cdat;
      vector_in = rows[i].vin;
      @(posedge clk);
      #1;
      chk($sformatf("%s_valid", rows[i].name), 256'(valid_out), 256'(rows[i].ev));
      if (rows[i].ev) begin
        chk($sformatf("%s_vec", rows[i].name), vector_out, rows[i].evec);
        chk($sformatf("%s_mask", rows[i].name), 256'(lane_half_out), 256'(rows[i].em));
      end
    end
    tracing = 1'b1;
    valid_in = 1'b1;
    eof_in = '0;
    chainId_in = 2'd1;
    configId = 8'd1;
    vector_in = ln('h5, 'h6, 'h7, 'h8, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst_mid_fill_valid", 256'(valid_out), 256'(0));
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 256'(valid_out), 256'(0));
    chk("rst_mid_vec", vector_out, '0);
    chk("rst_mid_mask", 256'(lane_half_out), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    valid_in = 1'b1;
    chainId_in = 2'd0;
    vector_in = ln(1, 2, 3, 4, 5, 6, 7, 8);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 256'(valid_out), 256'(1));
    chk("post_rst_vec", vector_out, ln(1, 2, 3, 4, 5, 6, 7, 8));
    chk("post_rst_mask", 256'(lane_half_out), 256'(0));
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 256'(valid_out), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
